chunked_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder/subtractor built from a CHUNK-bit full-adder slice plus a carry register.

---
 rtl/chunked_serial_adder.sv | 140 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle add/sub, one CHUNK-bit slice per cycle, LSB first.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
`ifdef ADDER_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             c_chunk;
    logic             last_chunk;

    always_comb begin
        a_chunk              = a_q[k_q*CHUNK +: CHUNK];
        b_chunk              = b_q[k_q*CHUNK +: CHUNK];
        {c_chunk, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk           = (k_q == KW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        s_d     = s_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Subtraction is A + ~B + 1, so B is inverted once at capture time.
                if (start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    k_d     = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d[k_q*CHUNK +: CHUNK] = sum_chunk;
                carry_d = c_chunk;
                if (last_chunk) begin
                    s_d     = work_d;
                    cout_d  = c_chunk;
`ifdef ADDER_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit of the top slice.
                    ovf_d   = (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum_chunk[CHUNK-1]) ^ c_chunk;
`endif
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            s_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            s_q     <= s_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign S    = s_q;
    assign Cout = cout_q;
`ifdef ADDER_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - self-checking bench for chunked_serial_adder.
module tb_chunked_serial_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A     = '0;
    logic [WIDTH-1:0] B     = '0;
    logic             Cin   = 1'b0;
    logic             Sub   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef ADDER_OVF_EN
    logic             Ovf;
`endif

    int checks   = 0;
    int failures = 0;

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sub   (Sub),
        .busy  (busy),
        .done  (done),
        .S     (S),
`ifdef ADDER_OVF_EN
        .Ovf   (Ovf),
`endif
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {ovf, cout, s}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        longint ua, ub, sa, sb, ur, sr, smax, smin;
        logic [WIDTH-1:0] s;
        logic c, v;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = a[WIDTH-1] ? ua - (64'sd1 <<< WIDTH) : ua;
        sb   = b[WIDTH-1] ? ub - (64'sd1 <<< WIDTH) : ub;
        smax = (64'sd1 <<< (WIDTH - 1)) - 1;
        smin = -(64'sd1 <<< (WIDTH - 1));
        if (sub) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + longint'(cin);
            c  = (ur >= (64'sd1 <<< WIDTH));
            sr = sa + sb + longint'(cin);
        end
        s = ur[WIDTH-1:0];
        v = (sr > smax) || (sr < smin);
        return {v, c, s};
    endfunction

    // One operation; scrambles inputs during RUN and reports timing observations.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         input logic sub, output logic [WIDTH-1:0] s_o, output logic c_o,
                         output logic v_o, output int lat, output int nbusy, output int bad);
        logic [WIDTH-1:0] s_prev;
        logic             c_prev;
        @(negedge clk);
        A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_prev = S; c_prev = Cout;
        lat = 1; nbusy = 0; bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nbusy++;
            if (S !== s_prev || Cout !== c_prev) bad++;
            A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) bad++;
        s_o = S; c_o = Cout;
`ifdef ADDER_OVF_EN
        v_o = Ovf;
`else
        v_o = 1'b0;
`endif
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, S, Cout} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b S=%h Cout=%b, want all 0", busy, done, S, Cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic run_directed(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin, input logic sub, input logic [WIDTH-1:0] es,
                                input logic ec);
        logic [WIDTH-1:0] s; logic c, v; int lat, nb, bad;
        do_op(a, b, cin, sub, s, c, v, lat, nb, bad);
        checks++;
        if (s !== es || c !== ec) begin
            failures++;
            $display("FAIL %s: got S=%h Cout=%b, want S=%h Cout=%b", nm, s, c, es, ec);
        end
        checks++;
        if (lat != NCHUNK + 1 || nb != NCHUNK || bad != 0) begin
            failures++;
            $display("FAIL %s_timing: lat=%0d busy=%0d glitches=%0d, want lat=%0d busy=%0d glitches=0",
                     nm, lat, nb, bad, NCHUNK + 1, NCHUNK);
        end
    endtask

    task automatic test_directed();
        run_directed("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        run_directed("carry_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
        run_directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        run_directed("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, s; logic cin, sub, c, v; logic [WIDTH+1:0] exp; int lat, nb, bad;
        for (int i = 0; i < 30; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            if (i == 0) begin a = '1; b = '1; end
            exp = model(a, b, cin, sub);
            do_op(a, b, cin, sub, s, c, v, lat, nb, bad);
            checks++;
            if (s !== exp[WIDTH-1:0] || c !== exp[WIDTH]) begin
                failures++;
                $display("FAIL random_%0d: A=%h B=%h Cin=%b Sub=%b got S=%h Cout=%b, want S=%h Cout=%b",
                         i, a, b, cin, sub, s, c, exp[WIDTH-1:0], exp[WIDTH]);
            end
`ifdef ADDER_OVF_EN
            checks++;
            if (v !== exp[WIDTH+1]) begin
                failures++;
                $display("FAIL random_ovf_%0d: got Ovf=%b, want %b", i, v, exp[WIDTH+1]);
            end
`endif
            checks++;
            if (lat != NCHUNK + 1 || nb != NCHUNK || bad != 0) begin
                failures++;
                $display("FAIL random_timing_%0d: lat=%0d busy=%0d glitches=%0d", i, lat, nb, bad);
            end
        end
    endtask

    task automatic test_midrun_start();
        logic [WIDTH+1:0] exp; int n, extra;
        exp = model(16'h0123, 16'h0456, 1'b0, 1'b0);
        @(negedge clk);
        A = 16'h0123; B = 16'h0456; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'hAAAA; B = 16'h1111; Sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || S !== exp[WIDTH-1:0] || Cout !== exp[WIDTH]) begin
            failures++;
            $display("FAIL midrun_start: done=%b S=%h Cout=%b, want done=1 S=%h Cout=%b",
                     done, S, Cout, exp[WIDTH-1:0], exp[WIDTH]);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL midrun_no_second_op: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH+1:0] e1, e2; int n;
        e1 = model(16'h8001, 16'h7FFF, 1'b0, 1'b0);
        e2 = model(16'h0100, 16'h0200, 1'b0, 1'b1);
        @(negedge clk);
        A = 16'h8001; B = 16'h7FFF; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (done !== 1'b1 || S !== e1[WIDTH-1:0] || Cout !== e1[WIDTH]) begin
            failures++;
            $display("FAIL b2b_first: done=%b S=%h Cout=%b, want done=1 S=%h Cout=%b",
                     done, S, Cout, e1[WIDTH-1:0], e1[WIDTH]);
        end
        A = 16'h0100; B = 16'h0200; Sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != NCHUNK + 1) begin
            failures++;
            $display("FAIL b2b_spacing: second done %0d cycles after first, want %0d", n, NCHUNK + 1);
        end
        checks++;
        if (S !== e2[WIDTH-1:0] || Cout !== e2[WIDTH]) begin
            failures++;
            $display("FAIL b2b_second: S=%h Cout=%b, want S=%h Cout=%b", S, Cout, e2[WIDTH-1:0], e2[WIDTH]);
        end
    endtask

    task automatic test_reset_midrun();
        logic [WIDTH-1:0] s; logic c, v; int lat, nb, bad, extra;
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, v, lat, nb, bad);
        @(negedge clk);
        A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, S, Cout} !== '0) begin
            failures++;
            $display("FAIL reset_midrun: busy=%b done=%b S=%h Cout=%b, want all 0", busy, done, S, Cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL reset_no_done: got %0d active cycles after release, want 0", extra);
        end
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] s; logic c, v; int lat, nb, bad;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat, nb, bad);
        checks++;
        if (v !== 1'b1 || s !== 16'h8000 || c !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pos: got Ovf=%b S=%h Cout=%b, want 1 8000 0", v, s, c);
        end
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, s, c, v, lat, nb, bad);
        checks++;
        if (v !== 1'b1 || s !== 16'h0000 || c !== 1'b1) begin
            failures++;
            $display("FAIL ovf_neg: got Ovf=%b S=%h Cout=%b, want 1 0000 1", v, s, c);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_midrun_start();
        test_back_to_back();
        test_reset_midrun();
`ifdef ADDER_OVF_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
